// File: rtl/hue_divider.sv
// Pipelined restoring divider: Q8.8 quotient of {dividend, 8'h00} / divisor,
// one quotient bit per stage, fixed 16-cycle latency, no backpressure.
module hue_divider #(
  parameter int DIVIDE_LATENCY = 16
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [7:0]  i_dividend,
  input  logic [7:0]  i_divisor,
  input  logic        i_valid,
  output logic [15:0] o_quotient,
  output logic        o_dbz,
  output logic        o_valid
);

  localparam int NS = 16;

  if (DIVIDE_LATENCY != NS) begin : g_bad_latency
    $error("hue_divider: DIVIDE_LATENCY must be 16");
  end

  // Valid/ready: i_valid is taken every cycle with no ready; o_valid pulses
  // once per accepted input exactly NS cycles later, in order.
  logic        valid_q [NS];
  logic        valid_d [NS];
  logic        dbz_q   [NS];
  logic        dbz_d   [NS];
  logic [15:0] quo_q   [NS];
  logic [15:0] quo_d   [NS];
  // The last stage needs no remainder, divisor or numerator carried forward.
  logic [7:0]  rem_q   [NS-1];
  logic [7:0]  rem_d   [NS-1];
  logic [7:0]  div_q   [NS-1];
  logic [7:0]  div_d   [NS-1];
  logic [15:0] num_q   [NS-1];
  logic [15:0] num_d   [NS-1];

  logic [15:0] quotient_q;
  logic        dbz_out_q;
  logic        valid_out_q;

  for (genvar k = 0; k < NS; k++) begin : g_stage
    logic       s_valid;
    logic       s_dbz;
    logic       s_bit;
    logic [7:0] s_rem;
    logic [7:0] s_div;
    logic [8:0] trial;
    logic [7:0] diff;
    logic       take;

    if (k == 0) begin : g_src
      assign s_valid  = i_valid;
      assign s_dbz    = (i_divisor == 8'h00);
      assign s_bit    = i_dividend[7];
      assign s_rem    = 8'h00;
      assign s_div    = i_divisor;
      assign quo_d[k] = {15'h0000, take};
    end else begin : g_src
      assign s_valid  = valid_q[k-1];
      assign s_dbz    = dbz_q[k-1];
      assign s_bit    = num_q[k-1][15];
      assign s_rem    = rem_q[k-1];
      assign s_div    = div_q[k-1];
      assign quo_d[k] = {quo_q[k-1][14:0], take};
    end

    // A zero divisor makes every compare succeed, giving 16'hFFFF.
    assign trial = {s_rem, s_bit};
    assign take  = (trial >= {1'b0, s_div});
    assign diff  = trial[7:0] - s_div;

    assign valid_d[k] = s_valid;
    assign dbz_d[k]   = s_dbz;

    if (k < NS - 1) begin : g_carry
      assign rem_d[k] = take ? diff : trial[7:0];
      assign div_d[k] = s_div;
      if (k == 0) begin : g_num
        assign num_d[k] = {i_dividend[6:0], 9'h000};
      end else begin : g_num
        assign num_d[k] = {num_q[k-1][14:0], 1'b0};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NS; k++) begin
      dbz_q[k] <= dbz_d[k];
      quo_q[k] <= quo_d[k];
    end
    for (int k = 0; k < NS - 1; k++) begin
      rem_q[k] <= rem_d[k];
      div_q[k] <= div_d[k];
      num_q[k] <= num_d[k];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int k = 0; k < NS; k++) begin
        valid_q[k] <= 1'b0;
      end
      valid_out_q <= 1'b0;
      quotient_q  <= 16'h0000;
      dbz_out_q   <= 1'b0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        valid_q[k] <= valid_d[k];
      end
      valid_out_q <= valid_q[NS-1];
      quotient_q  <= valid_q[NS-1] ? quo_q[NS-1] : 16'h0000;
      dbz_out_q   <= valid_q[NS-1] & dbz_q[NS-1];
    end
  end

  assign o_quotient = quotient_q;
  assign o_dbz      = dbz_out_q;
  assign o_valid    = valid_out_q;

endmodule

// File: tb/tb_hue_divider.sv
// Self-checking bench for hue_divider: per-cycle output check against an
// expected queue holding {valid, dbz, quotient} for the last 16 issue slots.
module tb_hue_divider;

  logic        i_clk;
  logic        i_rstn;
  logic [7:0]  i_dividend;
  logic [7:0]  i_divisor;
  logic        i_valid;
  logic [15:0] o_quotient;
  logic        o_dbz;
  logic        o_valid;

  hue_divider #(.DIVIDE_LATENCY(16)) dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .i_valid    (i_valid),
    .o_quotient (o_quotient),
    .o_dbz      (o_dbz),
    .o_valid    (o_valid)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // scoreboard
  logic [17:0] exp_q[$];
  int          n_compared;
  int          n_mismatched;
  string       phase;

  task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got v=%b dbz=%b q=%h, expected v=%b dbz=%b q=%h",
               tag, got[17], got[16], got[15:0], exp[17], exp[16], exp[15:0]);
    end
  endtask

  function automatic logic [17:0] model(input logic [7:0] a, input logic [7:0] b);
    int q;
    if (b == 8'd0) return {2'b11, 16'hFFFF};
    q = (int'(a) * 256) / int'(b);
    return {2'b10, q[15:0]};
  endfunction

  // driver: one edge per call, then check the output for that edge
  task automatic drive(input logic rstn, input logic v, input logic [7:0] a,
                       input logic [7:0] b, input logic [17:0] exp_w);
    logic [17:0] got;
    i_rstn     = rstn;
    i_valid    = v;
    i_dividend = a;
    i_divisor  = b;
    @(posedge i_clk);
    if (!rstn) begin
      foreach (exp_q[i]) exp_q[i] = 18'h0;
    end
    exp_q.push_back((rstn && v) ? exp_w : 18'h0);
    #1;
    got = {o_valid, o_dbz, o_quotient};
    check_eq(phase, got, exp_q.pop_front());
  endtask

  task automatic drive_m(input logic v, input logic [7:0] a, input logic [7:0] b);
    drive(1'b1, v, a, b, model(a, b));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 18'h0);
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    for (int i = 0; i < 16; i++) exp_q.push_back(18'h0);
    i_rstn = 1'b0; i_valid = 1'b0; i_dividend = 8'h0; i_divisor = 8'h0;

    phase = "reset";
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'd9, 8'd3, 18'h0);

    phase = "single";
    drive(1'b1, 1'b1, 8'd100, 8'd200, {2'b10, 16'h0080}); idle(3);
    drive(1'b1, 1'b1, 8'd200, 8'd100, {2'b10, 16'h0200}); idle(2);
    drive(1'b1, 1'b1, 8'd255, 8'd1,   {2'b10, 16'hFF00}); idle(4);
    drive(1'b1, 1'b1, 8'd1,   8'd255, {2'b10, 16'h0001}); idle(1);
    drive(1'b1, 1'b1, 8'd0,   8'd7,   {2'b10, 16'h0000}); idle(20);

    phase = "dbz";
    drive(1'b1, 1'b1, 8'd5, 8'd0, {2'b11, 16'hFFFF});
    drive(1'b1, 1'b1, 8'd5, 8'd5, {2'b10, 16'h0100});
    idle(20);

    phase = "b2b";
    for (int i = 0; i < 64; i++) begin
      drive_m(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    idle(20);

    phase = "bubble";
    drive_m(1'b1, 8'd77, 8'd13);
    drive_m(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    drive_m(1'b1, 8'd3,  8'd200);
    drive_m(1'b1, 8'd250, 8'd9);
    drive_m(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    idle(20);

    phase = "reset_mid";
    for (int i = 0; i < 8; i++) begin
      drive_m(1'b1, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
    end
    idle(4);
    drive(1'b0, 1'b1, 8'd40, 8'd2, 18'h0);
    drive(1'b1, 1'b1, 8'd60, 8'd3, {2'b10, 16'h1400});
    idle(20);

    phase = "sweep";
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        drive_m(1'b1, 8'(a), 8'(b));
      end
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/hue_divider.md
# hue_divider

Native pipelined unsigned fixed-point divider serving the hue pipeline. It receives the magnitude dividend and divisor that the hue datapath issues and returns an unsigned Q8.8 quotient plus a divide-by-zero flag after a fixed latency. It accepts one operand pair per clock and applies no backpressure, so it slots directly under the hue division stage as the vendor-independent divide engine.

## Interface
- DIVIDE_LATENCY, 16: pipeline depth in cycles. Must equal 16, one quotient bit per stage; any other value is a configuration error (elaboration-time check).
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rstn  in  1  reset, synchronous, active-low.
- i_dividend  in  8  unsigned dividend magnitude.
- i_divisor  in  8  unsigned divisor.
- i_valid  in  1  operand pair valid; sampled every cycle.
- o_quotient  out  16  unsigned Q8.8 quotient, floor(i_dividend*256/i_divisor).
- o_dbz  out  1  divisor was zero for this result.
- o_valid  out  1  result valid, one pulse per accepted input.

## Operation
- Numerator N = {i_dividend, 8'h00} (16 bits). Divisor D = i_divisor (8 bits).
- Restoring division, one stage per quotient bit, MSB first. Stage k (k = 0..15):
  - r' = {r[7:0], N[15-k]} (9 bits); r starts at 0.
  - If r' >= {1'b0, D}: q[15-k] = 1 and r = r' - D. Otherwise q[15-k] = 0 and r = r'.
  - The remainder always stays below D, so it fits in 8 bits between stages.
- Each stage registers: valid, remainder (8), divisor (8), unconsumed numerator bits, quotient bits so far, and the dbz flag (D == 0, captured at entry).
- The quotient cannot overflow. The maximum is 255*256/1 = 16'hFF00.
- D == 0: every compare succeeds, so the quotient is 16'hFFFF and o_dbz = 1. This value is required and checked.
- Stages advance every cycle regardless of i_valid. Bubbles propagate as invalid stages, and there is no stall input.
- When o_valid = 0, o_quotient and o_dbz are driven to 0.
- Operand and data registers need no reset. All valid bits and the output registers clear on reset.

## Timing
- Latency is exactly DIVIDE_LATENCY = 16 cycles. An input sampled with i_valid = 1 at rising edge T has its result on o_quotient, o_dbz and o_valid immediately after edge T+16.
- Throughput is 1 result per cycle. The i_valid pattern is reproduced on o_valid, delayed 16 cycles, including gaps.
- Results are returned in input order. There is no tag; the consumer delay-matches its side-band data (sign, function select) with a 16-deep shift register.
- Reset (i_rstn = 0 at an edge): at that edge every stage valid clears and the outputs become o_valid = 0, o_quotient = 0, o_dbz = 0.
- In-flight operations are discarded by reset and never emerge.
- Inputs presented while i_rstn = 0 are ignored.
- The first input accepted at the edge after reset deasserts produces its result 16 edges later.
- i_valid = 0 with arbitrary operand values must not affect any valid result, before or after.

## Test plan
- Single operations, with gaps between them:
  - 100/200 -> 16'h0080, dbz 0.
  - 200/100 -> 16'h0200.
  - 255/1 -> 16'hFF00.
  - 1/255 -> 16'h0001.
  - 0/7 -> 16'h0000.
  - Each result has o_valid high exactly 16 cycles after issue.
- Divide by zero: 5/0 -> 16'hFFFF, o_dbz 1. The following 5/5 -> 16'h0100, o_dbz 0.
- Back-to-back: 64 consecutive random pairs with i_valid held high -> 64 consecutive o_valid cycles, in order, each matching the floor(a*256/b) reference model.
- Bubbles: an i_valid pattern of 1,0,1,1,0 with random operands driven during the 0 cycles -> o_valid is 1,0,1,1,0 delayed 16 cycles, and the outputs are 0 in the gap cycles.
- Reset mid-flight:
  - Issue 8 ops, then assert i_rstn = 0 for 1 cycle at issue+5 -> none of the 8 results appear, and o_valid stays 0.
  - A new op issued after release returns correctly 16 cycles later.
- Exhaustive sweep of all 65536 (dividend, divisor) pairs, streamed -> every quotient and dbz flag matches the model.
